ps2_rx: RTL
===========

// Module: ps2_rx
// PURPOSE
//  PS/2 device-to-host receiver fully in the system clock domain; replaces the
//  ps2_clk-edge-clocked shifter. Synchronises and deglitches ps2_clk/ps2_data,
//  checks start/parity/stop and times out stalled frames. Delivers bytes over a
//  valid/ready handshake and keeps a CODE_BYTES-deep scan-code history for scan_codes.
// PARAMETERS
//  SYNC_STAGES  2       synchroniser flops per PS/2 line (>=2)
//  FILTER_LEN   4       clk cycles ps2_clk must hold a new level before it is accepted
//  TIMEOUT_CYC  100000  idle clk cycles between bit strobes before a frame aborts
//  CODE_BYTES   2       history depth in bytes; code width = 8*CODE_BYTES
// PORTS
//  clk         in   1              system clock
//  rst_n       in   1              synchronous active-low reset
//  ps2_clk     in   1              raw PS/2 clock, asynchronous
//  ps2_data    in   1              raw PS/2 data, asynchronous
//  byte_data   out  8              last accepted byte
//  byte_valid  out  1              byte_data holds an unconsumed byte
//  byte_ready  in   1              consumer accepts byte_data when high with byte_valid
//  code        out  8*CODE_BYTES   history; newest byte in [7:0], older bytes shift up
//  frame_err   out  1              1-cycle pulse: bad stop bit or timeout
//  parity_err  out  1              1-cycle pulse: odd-parity mismatch
//  overrun     out  1              1-cycle pulse: good byte dropped, byte_valid still high
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous, active-low (rst_n sampled on clk rising edge).
//  - Reset: synchroniser and filter flops = 1 (idle bus). State = IDLE, counters = 0.
//    byte_data = 0, byte_valid = 0, code = 0, all error pulses = 0.
//  - Reset mid-frame discards the partial frame; no error pulse is raised.
//  - Filter: filtered clock level changes only after FILTER_LEN consecutive equal
//    synchronised samples. A 1->0 transition of the filtered level is the bit strobe.
//    Synchronised ps2_data is sampled on the strobe cycle.
//  - FSM, advancing on strobes only:
//    IDLE: data==0 -> DATA with bit_cnt=0; data==1 -> stay in IDLE (ignored).
//    DATA: shift right (LSB first); after 8th bit -> PARITY.
//    PARITY: store bit -> STOP.
//    STOP: data==1 and ^{byte,parity}==1 -> deliver byte.
//          data==0 -> frame_err. Parity bad (stop ok) -> parity_err.
//          Always -> IDLE. Stop error takes priority; only one pulse per frame.
//  - Timeout: in DATA/PARITY/STOP a counter clears on each strobe and counts clk
//    otherwise. When it reaches TIMEOUT_CYC-1: frame_err pulse, -> IDLE.
//  - Delivery: on the cycle after the stop strobe, code <= {code[8*CODE_BYTES-9:0], byte}
//    (code updates on every good frame, independent of the handshake).
//    * byte_valid==0, or byte_ready==1 that cycle: byte_data <= byte, byte_valid <= 1.
//    * byte_valid==1 and byte_ready==0: byte dropped, byte_data is held, overrun pulse.
//  - Handshake: byte_valid stays high until a cycle with byte_ready==1. It then falls
//    on the next cycle unless a new delivery happens in that same cycle.
//  - Latency: stop-bit strobe -> byte_valid high = 1 clk. ps2 pin -> strobe =
//    SYNC_STAGES + FILTER_LEN clk.
//  - Errors never modify byte_data, byte_valid or code.
// STRUCTURE
//  - ps2_pkg: FSM state localparams (IDLE, DATA, PARITY, STOP) and PS2_FRAME_BITS=11.
//  - Sub-module ps2_line_filter (synchroniser + FILTER_LEN debounce, outputs
//    level + fall strobe), instantiated on ps2_clk. ps2_data uses only the SYNC_STAGES
//    synchroniser. FSM, timeout, handshake and history stay in ps2_rx.
// TESTING (defaults; bit period 20*FILTER_LEN clk)
//  1 Frame 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1), byte_ready=1 -> byte_valid
//    1 cycle, byte_data=0x1C, code=0x001C. Then F0,1C -> code 0x1CF0, then 0xF01C.
//  2 0x1C sent with parity=1 -> parity_err 1 pulse, no byte_valid, code unchanged.
//    Next good 0x5A -> accepted.
//  3 Frame 0x1C with stop=0 -> frame_err 1 pulse. 4 bits, then silence TIMEOUT_CYC ->
//    frame_err, FSM IDLE. Next 0x5A accepted.
//  4 byte_ready=0, send 0x1C then 0x32 -> byte_data=0x1C, overrun 1 pulse,
//    code=0x1C32. Then ready=1 for 1 cycle -> byte_valid low next cycle.
//  5 2-clk low glitch on idle ps2_clk (FILTER_LEN=4) -> no strobe. Then 0x1C -> exact
//    0x1C, no error pulses.
//  6 rst_n low 1 cycle after 5th data bit, then clean 0x29 -> byte_data=0x29, code=0x0029,
//    no error pulses.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;  // start + 8 data + parity + stop

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

endpackage

// File: rtl/ps2_rx_if.sv
// Byte delivery, scan-code history and error pulses of the PS/2 receiver.
// Handshake: byte_data is transferred on any clk cycle where byte_valid and byte_ready are both high;
// byte_valid never drops without such a cycle, and byte_data is stable while byte_valid is high.
interface ps2_rx_if #(
  parameter int CODE_BYTES = 2
) ();
  logic [7:0]              byte_data;
  logic                    byte_valid;
  logic                    byte_ready;
  logic [8*CODE_BYTES-1:0] code;
  logic                    frame_err;
  logic                    parity_err;
  logic                    overrun;

  modport master (
    output byte_data, byte_valid, code, frame_err, parity_err, overrun,
    input  byte_ready
  );

  modport slave (
    input  byte_data, byte_valid, code, frame_err, parity_err, overrun,
    output byte_ready
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Synchroniser plus debounce for one PS/2 line; emits the accepted level and a
// one-cycle strobe when the accepted level falls.
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      level  <= 1'b1;
      cnt_q  <= '0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line};
      fall   <= 1'b0;
      // Count consecutive samples disagreeing with the accepted level.
      if (sync_q[SYNC_STAGES-1] == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level <= sync_q[SYNC_STAGES-1];
        cnt_q <= '0;
        fall  <= level;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver running entirely on clk: frame FSM, timeout,
// valid/ready byte delivery and a multi-byte scan-code history.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int CODE_BYTES  = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   ps2_clk,
  input  logic   ps2_data,
  ps2_rx_if.master bus,
  output state_t dbg_state,
  output logic   dbg_clk_level
);

  localparam int W         = 8 * CODE_BYTES;
  localparam int TW        = $clog2(TIMEOUT_CYC);
  localparam int DATA_BITS = PS2_FRAME_BITS - 3;

  logic                   strobe;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   data_s;

  state_t    state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic       good, ferr, perr;

  logic [7:0] byte_data_q;
  logic       byte_valid_q;
  logic [W-1:0] code_q;
  logic       frame_err_q, parity_err_q, overrun_q;

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk  (clk),
    .rst_n(rst_n),
    .line (ps2_clk),
    .level(dbg_clk_level),
    .fall (strobe)
  );

  // Data is stable long before the clock falls, so it needs no debounce.
  always_ff @(posedge clk) begin
    if (!rst_n) data_sync_q <= '1;
    else        data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
  end
  assign data_s = data_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_d     = '0;
    good      = 1'b0;
    ferr      = 1'b0;
    perr      = 1'b0;
    case (state_q)
      IDLE: if (strobe && !data_s) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (strobe) begin
        shift_d   = {data_s, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
      end
      PARITY: if (strobe) begin
        parity_d = data_s;
        state_d  = STOP;
      end
      STOP: if (strobe) begin
        state_d = IDLE;
        if (!data_s)                 ferr = 1'b1;
        else if (^{shift_q, parity_q}) good = 1'b1;
        else                         perr = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Mid-frame stall watchdog; restarts on every bit strobe.
    if (state_q != IDLE && !strobe) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        ferr    = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      code_q       <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q  <= ferr;
      parity_err_q <= perr;
      overrun_q    <= 1'b0;
      if (good) begin
        code_q <= (code_q << 8) | W'(shift_q);
        if (!byte_valid_q || bus.byte_ready) begin
          byte_data_q  <= shift_q;
          byte_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (byte_valid_q && bus.byte_ready) begin
        byte_valid_q <= 1'b0;
      end
    end
  end

  assign bus.byte_data  = byte_data_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.code       = code_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.overrun    = overrun_q;
  assign dbg_state      = state_q;

endmodule
